// File: rtl/timer_irq_pkg.sv
// timer_irq_pkg: state encoding and parameter defaults shared by the timer interrupt controller.
package timer_irq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_CLEAR   = 2'd3;

  localparam int TIMEOUT_CYC_DEFAULT = 256;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_SERVICE = ST_SERVICE,
    S_CLEAR   = ST_CLEAR
  } state_e;

endpackage

// File: rtl/timer_irq_prio_enc.sv
// timer_irq_prio_enc: fixed-priority encoder, lowest set index wins.
module timer_irq_prio_enc
  import timer_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] cand,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: latches timer interrupt edges, arbitrates by fixed priority and runs the
// req/ack/eoi handshake; define TIMER_IRQ_TIMEOUT_EN to add the service timeout.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] src_clear,
  output logic [NUM_SRC-1:0] pending,
  output logic               timeout_flag
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536 || (1 << ID_W) < NUM_SRC) begin : g_param_check
    $error("timer_irq_ctrl: illegal parameter combination");
  end

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   irq_q, irq_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   src_clear_q, src_clear_d;
  logic                 irq_req_q, irq_req_d;
  logic [ID_W-1:0]      irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0]   id_onehot;
  logic                 enc_valid;
  logic [ID_W-1:0]      enc_idx;
  logic                 tmo_hit;

  timer_irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .cand  (pending_q & ~mask),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Edge latch: a fresh rising edge beats the clear of the serviced source.
  always_comb begin
    irq_d     = irq_in;
    pending_d = (pending_q & ~src_clear_q) | (irq_in & ~irq_q);
    for (int i = 0; i < NUM_SRC; i++) begin
      id_onehot[i] = (irq_id_q == ID_W'(i));
    end
  end

  // Handshake sequencing; outputs are precomputed so they leave straight from flops.
  always_comb begin
    state_d     = state_q;
    irq_req_d   = irq_req_q;
    irq_id_d    = irq_id_q;
    src_clear_d = '0;
    case (state_q)
      S_IDLE: begin
        if (enc_valid) begin
          state_d   = S_REQ;
          irq_req_d = 1'b1;
          irq_id_d  = enc_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          state_d   = S_SERVICE;
          irq_req_d = 1'b0;
        end else begin
          state_d = S_REQ;
        end
      end
      S_SERVICE: begin
        if (eoi || tmo_hit) begin
          state_d     = S_CLEAR;
          src_clear_d = id_onehot;
        end else begin
          state_d = S_SERVICE;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: begin
        state_d   = S_IDLE;
        irq_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      src_clear_q <= '0;
      irq_req_q   <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      pending_q   <= pending_d;
      src_clear_q <= src_clear_d;
      irq_req_q   <= irq_req_d;
      irq_id_q    <= irq_id_d;
    end
  end

`ifdef TIMER_IRQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_flag_q, tmo_flag_d;

  // Counter only advances in SERVICE, so it restarts at zero on each entry.
  always_comb begin
    tmo_hit    = 1'b0;
    tmo_cnt_d  = 16'd0;
    tmo_flag_d = tmo_flag_q;
    if (state_q == S_SERVICE) begin
      tmo_hit    = (tmo_cnt_q == TMO_LAST);
      tmo_cnt_d  = tmo_cnt_q + 16'd1;
      tmo_flag_d = tmo_flag_q | (tmo_hit & ~eoi);
    end else begin
      tmo_hit = 1'b0;
    end
  end

  // Timeout registers; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q  <= 16'd0;
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign timeout_flag = tmo_flag_q;
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign irq_req   = irq_req_q;
  assign irq_id    = irq_id_q;
  assign src_clear = src_clear_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed and random stimulus checked every cycle against a
// transaction-level model of the interrupt controller.
module tb_timer_irq_ctrl;

`ifdef TIMER_IRQ_TIMEOUT_EN
  localparam int TMO_EN = 1;
`else
  localparam int TMO_EN = 0;
`endif
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in, mask;
  logic       irq_ack, eoi;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] src_clear, pending;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;

  // Model: pending set, the one transaction in flight and where it is in the handshake.
  logic [3:0] m_prev, m_pend, m_clr;
  logic [1:0] m_id;
  logic       m_req, m_flag;
  bit         wait_ack, in_svc, clearing;
  int         svc_cycles;

  timer_irq_ctrl #(
    .NUM_SRC     (4),
    .ID_W        (2),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_in       (irq_in),
    .mask         (mask),
    .irq_ack      (irq_ack),
    .eoi          (eoi),
    .irq_req      (irq_req),
    .irq_id       (irq_id),
    .src_clear    (src_clear),
    .pending      (pending),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] rise, cand, nxt;
    bit found;
    if (!rst) begin
      m_prev = '0; m_pend = '0; m_clr = '0; m_id = '0; m_req = 1'b0; m_flag = 1'b0;
      wait_ack = 0; in_svc = 0; clearing = 0; svc_cycles = 0;
      return;
    end
    rise = irq_in & ~m_prev;
    nxt  = m_pend | rise;
    if (clearing) begin
      nxt[m_id] = rise[m_id];
      clearing  = 0;
      m_clr     = '0;
    end else if (in_svc) begin
      if (eoi || (TMO_EN == 1 && svc_cycles == TMO - 1)) begin
        if (!eoi) m_flag = 1'b1;
        in_svc   = 0;
        clearing = 1;
        m_clr    = 4'b0001 << m_id;
      end else begin
        svc_cycles++;
      end
    end else if (wait_ack) begin
      if (irq_ack) begin
        wait_ack   = 0;
        in_svc     = 1;
        m_req      = 1'b0;
        svc_cycles = 0;
      end
    end else begin
      cand  = m_pend & ~mask;
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (cand[i] && !found) begin
          found    = 1;
          m_id     = 2'(i);
          m_req    = 1'b1;
          wait_ack = 1;
        end
      end
    end
    m_prev = irq_in;
    m_pend = nxt;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("irq_req", irq_req, m_req);
      chk("irq_id", irq_id, m_id);
      chk("src_clear", src_clear, m_clr);
      chk("pending", pending, m_pend);
      chk("timeout_flag", timeout_flag, m_flag);
    end
  endtask

  // Acks and ends every outstanding interrupt the model knows about.
  task automatic drain(input string tag);
    int n = 0;
    while ((wait_ack || in_svc || clearing || (m_pend & ~mask) != 4'd0) && n < 200) begin
      irq_ack = wait_ack;
      eoi     = in_svc;
      cyc(1);
      n++;
    end
    irq_ack = 1'b0;
    eoi     = 1'b0;
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req && n < 10) begin
      cyc(1);
      n++;
    end
    chk(tag, irq_req, 1'b1);
  endtask

  initial begin
    rst = 1'b0; irq_in = 4'hF; mask = 4'h0; irq_ack = 1'b0; eoi = 1'b0;

    // 1: reset with all inputs high, then one latch on release
    cyc(2);
    chk("t1_rst_pend", pending, 4'h0);
    chk("t1_rst_req", irq_req, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk("t1_pend_all", pending, 4'hF);
    cyc(3);
    chk("t1_level_once", pending, 4'hF);
    irq_in = 4'h0;
    drain("t1_drain");

    // 2: single source, exact latency and clear pulse
    irq_in = 4'b0100;
    cyc(1);
    chk("t2_pend", pending, 4'b0100);
    chk("t2_req_early", irq_req, 1'b0);
    cyc(1);
    chk("t2_req", irq_req, 1'b1);
    chk("t2_id", irq_id, 2'd2);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    chk("t2_ack", irq_req, 1'b0);
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    chk("t2_clr", src_clear, 4'b0100);
    cyc(1);
    chk("t2_clr_off", src_clear, 4'b0000);
    chk("t2_pend_off", pending, 4'b0000);

    // 3: simultaneous edges, lowest index first
    irq_in = 4'b1110;
    cyc(2);
    chk("t3_first_id", irq_id, 2'd1);
    drain("t3_drain");
    chk("t3_last_id", irq_id, 2'd3);

    // 4: masked source latches but does not request
    mask = 4'b0001; irq_in = 4'b1111;
    cyc(4);
    chk("t4_masked_req", irq_req, 1'b0);
    chk("t4_masked_pend", pending, 4'b0001);
    mask = 4'b0000;
    cyc(2);
    chk("t4_unmask_req", irq_req, 1'b1);
    chk("t4_unmask_id", irq_id, 2'd0);
    drain("t4_drain");

    // 5: stray ack/eoi, then a new edge landing in CLEAR of the same source
    irq_ack = 1'b1; eoi = 1'b1; cyc(1); irq_ack = 1'b0; eoi = 1'b0;
    irq_in = 4'b1011; cyc(2);
    irq_in = 4'b1111;
    wait_req("t5_req");
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    chk("t5_eoi_in_req", irq_req, 1'b1);
    irq_ack = 1'b1; eoi = 1'b1; cyc(1); irq_ack = 1'b0; eoi = 1'b0;
    chk("t5_ack_only_clr", src_clear, 4'b0000);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    irq_in = 4'b1011;
    eoi = 1'b1; cyc(1); eoi = 1'b0;
    chk("t5_clr", src_clear, 4'b0100);
    irq_in = 4'b1111;
    cyc(1);
    chk("t5_set_wins", pending, 4'b0100);
    cyc(1);
    chk("t5_rereq_id", irq_id, 2'd2);
    drain("t5_drain");

    // 6: acked but never ended
    irq_in = 4'b1101; cyc(1);
    irq_in = 4'b1111;
    wait_req("t6_req");
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    cyc(100);
    chk("t6_flag", timeout_flag, 1'(TMO_EN));
    drain("t6_drain");
    rst = 1'b0; cyc(1); rst = 1'b1;
    chk("t6_flag_rst", timeout_flag, 1'b0);
    irq_in = 4'h0; cyc(2);

    // random traffic
    for (int r = 0; r < 600; r++) begin
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 2) == 0);
      rst     = ($urandom_range(0, 99) != 0);
      cyc(1);
    end
    rst = 1'b1; irq_ack = 1'b0; eoi = 1'b0; mask = 4'h0;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
